// File: rtl/mmio_regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mmio_regfile_pkg
//  Purpose  : Default register map and region-decode helpers for mmio_regfile.
//  Revision : 1.0  initial release
// ============================================================================
package mmio_regfile_pkg;

    localparam int DEF_OUT_BASE  = 1;
    localparam int DEF_N_OUT     = 6;
    localparam int DEF_IN_BASE   = 8;
    localparam int DEF_N_IN      = 3;
    localparam int DEF_EV_ADDR   = 11;
    localparam int DEF_STAT_ADDR = 12;

    function automatic bit in_window(int idx, int base, int n);
        return (idx >= base) && (idx < base + n);
    endfunction

    function automatic bit is_in(int idx, int base, int n);
        return in_window(idx, base, n);
    endfunction

    function automatic bit is_out(int idx, int base, int n);
        return in_window(idx, base, n);
    endfunction

    function automatic bit is_ev(int idx, int ev_addr);
        return idx == ev_addr;
    endfunction

    function automatic bit is_stat(int idx, int stat_addr);
        return idx == stat_addr;
    endfunction

    function automatic bit windows_overlap(int a_base, int a_n, int b_base, int b_n);
        return (a_n > 0) && (b_n > 0) && (a_base < b_base + b_n) && (b_base < a_base + a_n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_regfile_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mmio_regfile_if
//  Purpose  : CPU-side write/read port bundle of the register file.
//  Revision : 1.0  initial release
// ============================================================================
interface mmio_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB
    );
endinterface
`default_nettype wire

// File: rtl/mmio_regfile_event_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : event_sync
//  Purpose  : One-bit pin synchroniser with polarity normalise and rising-edge detect.
//  Revision : 1.0  initial release
// ============================================================================
module event_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit ACT_LOW     = 1'b1
) (
    input  wire logic clock,
    input  wire logic ctrl_reset,
    input  wire logic pin_i,
    output logic      level_o,
    output logic      rise_o
);
    if (SYNC_STAGES < 2) begin : g_bad_depth
        $error("event_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_prev_q;

    // Flops reset to the inactive pin level so reset release never looks like an edge
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            sync_q       <= {SYNC_STAGES{ACT_LOW}};
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], pin_i};
            level_prev_q <= level_o;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1] ^ ACT_LOW;
    assign rise_o  = level_o & ~level_prev_q;
endmodule
`default_nettype wire

// File: rtl/mmio_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mmio_regfile
//  Purpose  : CPU register file with output/input-mapped windows and sticky events.
//  Revision : 1.0  initial release
// ============================================================================
module mmio_regfile
    import mmio_regfile_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int OUT_BASE    = DEF_OUT_BASE,
    parameter int N_OUT       = DEF_N_OUT,
    parameter int IN_BASE     = DEF_IN_BASE,
    parameter int N_IN        = DEF_N_IN,
    parameter int N_EV        = 2,
    parameter int EV_ADDR     = DEF_EV_ADDR,
    parameter int STAT_ADDR   = DEF_STAT_ADDR,
    parameter bit EV_ACT_LOW  = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter bit BYPASS      = 1'b1
) (
    input  wire logic                    clock,
    input  wire logic                    ctrl_reset,
    mmio_regfile_if.slave                bus,
    input  wire logic [N_IN*DATA_W-1:0]  in_words,
    input  wire logic [N_EV-1:0]         ev_pins,
    output logic      [N_OUT*DATA_W-1:0] out_words,
    output logic      [N_OUT-1:0]        out_strobe,
    output logic                         ev_pending
);
    localparam int NUM_REGS = 2**ADDR_W;

    localparam bit MAP_BAD =
        (OUT_BASE < 1) || (IN_BASE < 1) || (EV_ADDR < 1) || (STAT_ADDR < 1) ||
        (OUT_BASE + N_OUT > NUM_REGS) || (IN_BASE + N_IN > NUM_REGS) ||
        (EV_ADDR >= NUM_REGS) || (STAT_ADDR >= NUM_REGS) ||
        windows_overlap(OUT_BASE, N_OUT, IN_BASE, N_IN) ||
        windows_overlap(OUT_BASE, N_OUT, EV_ADDR, 1) ||
        windows_overlap(OUT_BASE, N_OUT, STAT_ADDR, 1) ||
        windows_overlap(IN_BASE, N_IN, EV_ADDR, 1) ||
        windows_overlap(IN_BASE, N_IN, STAT_ADDR, 1) ||
        (EV_ADDR == STAT_ADDR) || (N_EV < 1) || (N_EV > DATA_W);

    if (MAP_BAD) begin : g_bad_map
        $error("mmio_regfile: illegal register map");
    end

    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [N_IN*DATA_W-1:0] in_q;
    logic [N_EV-1:0]        ev_q, ev_d, ev_set, ev_clr, ev_lvl;
    logic [N_OUT-1:0]       strobe_q, strobe_d;
    logic                   ev_pending_q;
    logic                   wr_gen_en;
    logic [DATA_W-1:0]      rd_a, rd_b;

    // Only index 0 and the input/event/status slots refuse CPU writes
    function automatic bit writable(logic [ADDR_W-1:0] idx);
        int i;
        i = int'(idx);
        return (i != 0) && !is_in(i, IN_BASE, N_IN) && !is_ev(i, EV_ADDR) && !is_stat(i, STAT_ADDR);
    endfunction

    assign wr_gen_en = bus.ctrl_writeEnable && writable(bus.ctrl_writeReg);

    always_comb begin
        strobe_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            strobe_d[k] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(OUT_BASE + k));
        end
        ev_clr = '0;
        if (bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(EV_ADDR))) begin
            ev_clr = bus.data_writeReg[N_EV-1:0];
        end
        // A fresh edge wins over a coincident clear of the same bit
        ev_d = (ev_q & ~ev_clr) | ev_set;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            in_q         <= '0;
            ev_q         <= '0;
            strobe_q     <= '0;
            ev_pending_q <= 1'b0;
        end else begin
            if (wr_gen_en) begin
                regs_q[bus.ctrl_writeReg] <= bus.data_writeReg;
            end
            in_q         <= in_words;
            ev_q         <= ev_d;
            strobe_q     <= strobe_d;
            ev_pending_q <= |ev_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] r;
        int                i;
        i = int'(idx);
        r = regs_q[idx];
        for (int k = 0; k < N_IN; k++) begin
            if (i == IN_BASE + k) r = in_q[k*DATA_W +: DATA_W];
        end
        if (i == EV_ADDR)   r = DATA_W'(ev_q);
        if (i == STAT_ADDR) r = DATA_W'(ev_lvl);
        if (BYPASS && wr_gen_en && (idx == bus.ctrl_writeReg)) r = bus.data_writeReg;
        return r;
    endfunction

    always_comb begin
        rd_a = read_port(bus.ctrl_readRegA);
        rd_b = read_port(bus.ctrl_readRegB);
    end

    assign bus.data_readRegA = rd_a;
    assign bus.data_readRegB = rd_b;
    assign out_strobe        = strobe_q;
    assign ev_pending        = ev_pending_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_words[k*DATA_W +: DATA_W] = regs_q[OUT_BASE + k];
    end

    for (genvar k = 0; k < N_EV; k++) begin : g_ev
        event_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .ACT_LOW     (EV_ACT_LOW)
        ) u_sync (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .pin_i      (ev_pins[k]),
            .level_o    (ev_lvl[k]),
            .rise_o     (ev_set[k])
        );
    end
endmodule
`default_nettype wire

// File: tb/tb_mmio_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_regfile
//  Purpose  : Directed self-checking bench for mmio_regfile.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_regfile;
    logic         clock = 1'b0;
    logic         ctrl_reset = 1'b1;
    logic [95:0]  in_words;
    logic [1:0]   ev_pins;
    logic [191:0] out_words;
    logic [5:0]   out_strobe;
    logic         ev_pending;
    int           tests = 0;
    int           fails = 0;

    mmio_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mmio_regfile dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus),
        .in_words   (in_words),
        .ev_pins    (ev_pins),
        .out_words  (out_words),
        .out_strobe (out_strobe),
        .ev_pending (ev_pending)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        ctrl_reset = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.ctrl_readRegA = 5'(i);
            #1;
            tests++;
            if (bus.data_readRegA !== 32'h0) begin
                fails++;
                $display("FAIL reset_read r%0d: got %h expected %h", i, bus.data_readRegA, 32'h0);
            end
        end
        tests++;
        if (out_strobe !== 6'h0 || ev_pending !== 1'b0 || out_words !== 192'h0) begin
            fails++;
            $display("FAIL reset_outputs: strobe=%b pending=%b words=%h expected all zero",
                     out_strobe, ev_pending, out_words);
        end
    endtask

    task automatic test_r0;
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd0;
        bus.data_writeReg    = 32'hDEADBEEF;
        bus.ctrl_readRegA    = 5'd0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0) begin
            fails++;
            $display("FAIL r0_no_bypass: got %h expected %h", bus.data_readRegA, 32'h0);
        end
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0) begin
            fails++;
            $display("FAIL r0_write_ignored: got %h expected %h", bus.data_readRegA, 32'h0);
        end
    endtask

    task automatic test_out;
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd1;
        bus.data_writeReg    = 32'h5;
        bus.ctrl_readRegA    = 5'd1;
        bus.ctrl_readRegB    = 5'd1;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h5 || bus.data_readRegB !== 32'h5) begin
            fails++;
            $display("FAIL bypass_r1: got A=%h B=%h expected 5", bus.data_readRegA, bus.data_readRegB);
        end
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (out_words[31:0] !== 32'h5 || out_strobe !== 6'b000001) begin
            fails++;
            $display("FAIL out_r1: got word=%h strobe=%b expected 5 / 000001", out_words[31:0], out_strobe);
        end
        tick();
        tests++;
        if (out_strobe !== 6'b000000 || out_words[31:0] !== 32'h5) begin
            fails++;
            $display("FAIL strobe_one_cycle: got strobe=%b word=%h expected 000000 / 5", out_strobe, out_words[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd2;
        bus.data_writeReg    = 32'h11;
        tick();
        bus.ctrl_writeReg    = 5'd3;
        bus.data_writeReg    = 32'h22;
        #1;
        tests++;
        if (out_strobe !== 6'b000010) begin
            fails++;
            $display("FAIL b2b_strobe_r2: got %b expected %b", out_strobe, 6'b000010);
        end
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (out_strobe !== 6'b000100 || out_words[63:32] !== 32'h11 || out_words[95:64] !== 32'h22) begin
            fails++;
            $display("FAIL b2b_r3: got strobe=%b r2=%h r3=%h expected 000100 / 11 / 22",
                     out_strobe, out_words[63:32], out_words[95:64]);
        end
        // general-purpose register: bypass on A, stored value on B, no strobe
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd20;
        bus.data_writeReg    = 32'h12345678;
        bus.ctrl_readRegA    = 5'd20;
        bus.ctrl_readRegB    = 5'd19;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h12345678 || bus.data_readRegB !== 32'h0) begin
            fails++;
            $display("FAIL bypass_r20: got A=%h B=%h expected 12345678 / 0", bus.data_readRegA, bus.data_readRegB);
        end
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h12345678 || out_strobe !== 6'b0) begin
            fails++;
            $display("FAIL store_r20: got A=%h strobe=%b expected 12345678 / 000000", bus.data_readRegA, out_strobe);
        end
    endtask

    task automatic test_in;
        in_words[31:0]    = 32'h3;
        in_words[95:64]   = 32'hCAFEF00D;
        bus.ctrl_readRegA = 5'd8;
        bus.ctrl_readRegB = 5'd10;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0) begin
            fails++;
            $display("FAIL in_not_live: got %h expected %h", bus.data_readRegA, 32'h0);
        end
        tick();
        tests++;
        if (bus.data_readRegA !== 32'h3 || bus.data_readRegB !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL in_load: got r8=%h r10=%h expected 3 / cafef00d", bus.data_readRegA, bus.data_readRegB);
        end
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd8;
        bus.data_writeReg    = 32'h77;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h3) begin
            fails++;
            $display("FAIL in_no_bypass: got %h expected %h", bus.data_readRegA, 32'h3);
        end
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h3) begin
            fails++;
            $display("FAIL in_write_ignored: got %h expected %h", bus.data_readRegA, 32'h3);
        end
    endtask

    task automatic test_event;
        bus.ctrl_readRegA = 5'd11;
        bus.ctrl_readRegB = 5'd12;
        ev_pins = 2'b10;
        tick();
        tick();
        tests++;
        if (bus.data_readRegB !== 32'h1 || bus.data_readRegA !== 32'h0 || ev_pending !== 1'b0) begin
            fails++;
            $display("FAIL ev_latency2: got stat=%h sticky=%h pending=%b expected 1 / 0 / 0",
                     bus.data_readRegB, bus.data_readRegA, ev_pending);
        end
        tick();
        tests++;
        if (bus.data_readRegA !== 32'h1 || ev_pending !== 1'b1) begin
            fails++;
            $display("FAIL ev_set: got sticky=%h pending=%b expected 1 / 1", bus.data_readRegA, ev_pending);
        end
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd11;
        bus.data_writeReg    = 32'h1;
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0 || ev_pending !== 1'b0 || bus.data_readRegB !== 32'h1) begin
            fails++;
            $display("FAIL ev_w1c: got sticky=%h pending=%b stat=%h expected 0 / 0 / 1",
                     bus.data_readRegA, ev_pending, bus.data_readRegB);
        end
    endtask

    task automatic test_event_race;
        ev_pins = 2'b11;
        repeat (3) tick();
        tests++;
        if (bus.data_readRegB !== 32'h0 || bus.data_readRegA !== 32'h0) begin
            fails++;
            $display("FAIL ev_release: got stat=%h sticky=%h expected 0 / 0", bus.data_readRegB, bus.data_readRegA);
        end
        ev_pins = 2'b10;
        tick();
        tick();
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd11;
        bus.data_writeReg    = 32'h1;
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h1 || ev_pending !== 1'b1) begin
            fails++;
            $display("FAIL ev_set_wins: got sticky=%h pending=%b expected 1 / 1", bus.data_readRegA, ev_pending);
        end
        bus.ctrl_writeEnable = 1'b1;
        bus.data_writeReg    = 32'h2;
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h1) begin
            fails++;
            $display("FAIL ev_w1c_other_bit: got %h expected %h", bus.data_readRegA, 32'h1);
        end
        ev_pins = 2'b00;
        repeat (3) tick();
        tests++;
        if (bus.data_readRegA !== 32'h3 || bus.data_readRegB !== 32'h3) begin
            fails++;
            $display("FAIL ev_both: got sticky=%h stat=%h expected 3 / 3", bus.data_readRegA, bus.data_readRegB);
        end
        bus.ctrl_writeEnable = 1'b1;
        bus.data_writeReg    = 32'hFFFF_FFFF;
        tick();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0 || ev_pending !== 1'b0) begin
            fails++;
            $display("FAIL ev_clear_all: got sticky=%h pending=%b expected 0 / 0", bus.data_readRegA, ev_pending);
        end
        ev_pins = 2'b11;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_write;
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd2;
        bus.data_writeReg    = 32'h9;
        #3;
        ctrl_reset = 1'b1;
        #1;
        tests++;
        if (out_words[63:32] !== 32'h0 || out_words[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL rst_immediate: got r1=%h r2=%h expected 0 / 0", out_words[31:0], out_words[63:32]);
        end
        @(posedge clock);
        #1;
        tests++;
        if (out_strobe !== 6'b0 || out_words[63:32] !== 32'h0) begin
            fails++;
            $display("FAIL rst_no_commit: got strobe=%b r2=%h expected 000000 / 0", out_strobe, out_words[63:32]);
        end
        bus.ctrl_writeEnable = 1'b0;
        tick();
        ctrl_reset = 1'b0;
        repeat (4) tick();
        bus.ctrl_readRegA = 5'd11;
        bus.ctrl_readRegB = 5'd8;
        #1;
        tests++;
        if (bus.data_readRegA !== 32'h0 || ev_pending !== 1'b0 || out_strobe !== 6'b0 ||
            bus.data_readRegB !== 32'h3) begin
            fails++;
            $display("FAIL rst_release: got sticky=%h pending=%b strobe=%b r8=%h expected 0 / 0 / 000000 / 3",
                     bus.data_readRegA, ev_pending, out_strobe, bus.data_readRegB);
        end
    endtask

    initial begin
        in_words             = '0;
        ev_pins              = 2'b11;
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
        bus.ctrl_readRegA    = '0;
        bus.ctrl_readRegB    = '0;
        test_reset();
        test_r0();
        test_out();
        test_back_to_back();
        test_in();
        test_event();
        test_event_race();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
